adau_i2s_receiver: RTL
======================

# adau_i2s_receiver

Capture side of the ADAU1761 audio path. It oversamples the codec's I2S bit clock, word clock and ADC serial data in the `clk_soc` domain. It deserialises 24-bit left/right samples and buffers complete stereo frames in a small FIFO. The CPU bus logic reads frames out of that FIFO. It sits beside `i2s_master`, shares its `ac_bclk`/`ac_lrclk`, and takes `ac_adc_sdata` from the codec.

## Interface
Parameters:
- `DATA_WIDTH`, 24: sample width in bits, MSB-first; 1..31.
- `SLOT_WIDTH`, 32: bclk cycles per channel slot; must exceed `DATA_WIDTH`.
- `FIFO_AW`, 2: log2 of FIFO depth in stereo frames; default depth is 4.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock (`clk_soc`); must be at least 4× the bclk frequency.
- `resetn` in 1: synchronous active-low reset.
- `bclk` in 1: I2S bit clock, asynchronous to `clk`.
- `lrclk` in 1: word clock; low = left, high = right.
- `sdata` in 1: ADC serial data.
- `frame_l` out `DATA_WIDTH`: left sample at the FIFO head.
- `frame_r` out `DATA_WIDTH`: right sample at the FIFO head.
- `frame_valid` out 1: FIFO not empty.
- `frame_ready` in 1: pop strobe; consumed only when `frame_valid` is 1.
- `fill` out `FIFO_AW+1`: number of frames in the FIFO.
- `overflow` out 1: sticky flag, set when a frame is dropped.
- `overflow_clr` in 1: clears `overflow`.

## Operation
- **Input sampling.** `bclk`, `lrclk` and `sdata` are sampled each `clk` (see Configuration). A bclk rising edge (`rise`) is detected as sampled bclk = 1 while the previous sample = 0. All capture logic advances only on `rise`.
- **lrclk tracking.** On each `rise` the sampled lrclk is compared with the value held at the previous `rise`; a difference is `lr_edge`.
- **States.**
  - SYNC: wait for the first lrclk 1→0 `lr_edge` (start of left slot), then go to LEFT.
  - LEFT: I2S one-bit delay. The `rise` that carries `lr_edge` is skipped. The next `DATA_WIDTH` `rise`s shift `sdata` into the left shift register, MSB first. Remaining slot bits are ignored. A 0→1 `lr_edge` moves to RIGHT, but only if all `DATA_WIDTH` bits were captured; otherwise go to SYNC and discard.
  - RIGHT: same delay and capture into the right register. A 1→0 `lr_edge` with a full word pushes {L,R} into the FIFO, then enters LEFT with that `rise` as the delay bit. A short word goes to SYNC with nothing pushed.
- **Bit counter.** Width clog2(`SLOT_WIDTH`)+1. It saturates at `SLOT_WIDTH`; bits beyond `DATA_WIDTH` are not shifted.
- **FIFO.** Circular buffer of 2^`FIFO_AW` frames with wrapping read/write pointers.
  - Push into a full FIFO: push with no pop in the same cycle drops the new frame, keeps FIFO contents, and sets `overflow`.
  - Push and pop in the same cycle while full: both happen, `fill` unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only (`frame_valid` is still 0 that cycle).
  - `frame_ready` while empty is ignored.
- **`overflow` flag.** Set has priority over `overflow_clr` in the same cycle.
- **Reset.** Reset mid-frame discards the partial word and the FIFO contents, and returns to SYNC.

## Timing
- **Reset values.** With `resetn` = 0 at a `clk` edge: `frame_valid` = 0, `frame_l` = `frame_r` = 0, `fill` = 0, `overflow` = 0; state SYNC; pointers and counter 0.
- **Push latency.** `frame_valid` rises 1 `clk` after the `rise` that completes the frame, so input-pin-to-`frame_valid` is sync depth + 2 `clk`.
- **Head data.** `frame_l`/`frame_r` are registered head-of-FIFO outputs. They show the next frame the cycle after a pop; `frame_valid` and `fill` update in that same cycle.
- **Throughput.** One pop per `clk`; one push per lrclk period (64 bclk at default parameters).

## Configuration
- **`ADAU_I2S_RX_SYNC_EN` defined:** each of `bclk`, `lrclk` and `sdata` passes through a 2-FF synchronizer plus one edge-history register. Pin-to-`rise` latency is 3 `clk`.
- **Undefined:** a single register stage plus the history register, for when bclk is derived synchronously from `clk` (e.g. simulation, or loopback from `i2s_master`). Latency is 1 `clk` shorter. Functional behaviour is otherwise identical.

## Test plan
- **Basic capture:** `clk` = 100 MHz, bclk = 3.072 MHz, 64 bclk/frame, send L = 0x123456, R = 0xABCDEF after one sync frame → `frame_valid` = 1, `frame_l` = 0x123456, `frame_r` = 0xABCDEF, `fill` = 1; pop → `frame_valid` = 0.
- **Start mid-right slot:** release reset in the middle of a right slot, send frames (0x000001, 0x800000), (0x7FFFFF, 0xFFFFFF) → first partial frame not pushed; exactly these two frames are read back in order.
- **Overflow:** send 5 frames with no pop → `fill` = 4, `overflow` = 1, frames 1–4 retained, frame 5 lost. Assert `overflow_clr` in the same cycle as a 6th dropped push → `overflow` stays 1.
- **Simultaneous push/pop:** full FIFO, pulse `frame_ready` in the push cycle → `fill` stays 4, `overflow` = 0, FIFO order intact.
- **Short word:** toggle lrclk after 20 bits of the left word → no push, state SYNC; the next two clean frames are captured correctly.
- **Reset mid-operation:** `resetn` = 0 for 1 `clk` with `fill` = 3 and a frame half-received → `fill` = 0, `frame_valid` = 0, `overflow` = 0; the next full frame after a left-slot start is captured.

Source files
------------

// File: rtl/adau_i2s_receiver.sv
// ADAU1761 I2S capture: oversamples bclk/lrclk/sdata, deserialises 24-bit stereo frames into a small FIFO.
// Define ADAU_I2S_RX_SYNC_EN to add a 2-FF synchronizer on the I2S pins when bclk is asynchronous to clk.
module adau_i2s_receiver #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int FIFO_AW    = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  bclk,
   input  logic                  lrclk,
   input  logic                  sdata,
   output logic [DATA_WIDTH-1:0] frame_l,
   output logic [DATA_WIDTH-1:0] frame_r,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic [FIFO_AW:0]      fill,
   output logic                  overflow,
   input  logic                  overflow_clr
);
   localparam int CW    = $clog2(SLOT_WIDTH) + 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [CW-1:0]      DW_CNT    = CW'(DATA_WIDTH);
   localparam logic [CW-1:0]      SW_CNT    = CW'(SLOT_WIDTH);
   localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT} state_t;

   // pins_q holds {bclk, lrclk, sdata} as seen by the capture logic
   logic [2:0] pins_q;
`ifdef ADAU_I2S_RX_SYNC_EN
   logic [2:0] meta_q;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta_q <= '0;
         pins_q <= '0;
      end else begin
         meta_q <= {bclk, lrclk, sdata};
         pins_q <= meta_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!resetn) pins_q <= '0;
      else         pins_q <= {bclk, lrclk, sdata};
   end
`endif

   logic bclk_hist_q;
   always_ff @(posedge clk) begin
      if (!resetn) bclk_hist_q <= 1'b0;
      else         bclk_hist_q <= pins_q[2];
   end

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic                  lr_prev_q;
   logic [DATA_WIDTH-1:0] left_q, right_q;
   logic                  push_q;
   logic                  rise, lr_edge, lr_s, sd_s, full_word;

   assign rise      = pins_q[2] & ~bclk_hist_q;
   assign lr_s      = pins_q[1];
   assign sd_s      = pins_q[0];
   assign lr_edge   = rise & (lr_s != lr_prev_q);
   assign full_word = (cnt_q >= DW_CNT);

   // The rise carrying lr_edge is the I2S delay bit, so it never shifts data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_SYNC;
         cnt_q     <= '0;
         lr_prev_q <= 1'b0;
         left_q    <= '0;
         right_q   <= '0;
         push_q    <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (rise) begin
            lr_prev_q <= lr_s;
            unique case (state_q)
               S_SYNC: begin
                  if (lr_edge && !lr_s) begin
                     state_q <= S_LEFT;
                     cnt_q   <= '0;
                  end
               end
               S_LEFT: begin
                  if (lr_edge) begin
                     cnt_q   <= '0;
                     state_q <= (lr_s && full_word) ? S_RIGHT : S_SYNC;
                  end else begin
                     if (cnt_q < DW_CNT) left_q <= DATA_WIDTH'({left_q, sd_s});
                     if (cnt_q < SW_CNT) cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_RIGHT: begin
                  if (lr_edge) begin
                     cnt_q <= '0;
                     if (!lr_s && full_word) begin
                        push_q  <= 1'b1;
                        state_q <= S_LEFT;
                     end else begin
                        state_q <= S_SYNC;
                     end
                  end else begin
                     if (cnt_q < DW_CNT) right_q <= DATA_WIDTH'({right_q, sd_s});
                     if (cnt_q < SW_CNT) cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: state_q <= S_SYNC;
            endcase
         end
      end
   end

   // left_q/right_q stay stable for several clk after the pushing rise, so the FIFO writes them directly.
   logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [2*DATA_WIDTH-1:0] head_q, wdata;
   logic [FIFO_AW-1:0]      rd_q, wr_q, rd_d, wr_d;
   logic [FIFO_AW:0]        count_q, count_d;
   logic                    ovf_q, pop, full, do_push, drop;

   always_comb begin
      wdata   = {left_q, right_q};
      pop     = frame_ready && (count_q != '0);
      full    = (count_q == DEPTH_CNT);
      do_push = push_q && (!full || pop);
      drop    = push_q && full && !pop;
      rd_d    = pop ? rd_q + FIFO_AW'(1) : rd_q;
      wr_d    = do_push ? wr_q + FIFO_AW'(1) : wr_q;
      count_d = count_q;
      unique case ({do_push, pop})
         2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

   // Head register reads at the next read pointer; bypass when that slot is being written now.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         if (count_d == '0)                 head_q <= '0;
         else if (do_push && (wr_q == rd_d)) head_q <= wdata;
         else                                head_q <= mem_q[rd_d];
         if (drop)              ovf_q <= 1'b1;
         else if (overflow_clr) ovf_q <= 1'b0;
      end
   end

   assign frame_l     = head_q[2*DATA_WIDTH-1:DATA_WIDTH];
   assign frame_r     = head_q[DATA_WIDTH-1:0];
   assign frame_valid = (count_q != '0);
   assign fill        = count_q;
   assign overflow    = ovf_q;

endmodule
